// File: rtl/rice_core_bus_arbiter.sv
// rice_core_bus_arbiter: shares the core memory port between IF and load/store requesters, routing in-order responses by queued ID.
// Define RICE_BUS_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; otherwise data wins over instruction.
module rice_core_bus_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_OUTSTANDING = 2,
  localparam int STROBE_WIDTH = DATA_WIDTH / 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_inst_request_valid,
  output logic                     o_inst_request_ready,
  input  logic [ADDRESS_WIDTH-1:0] i_inst_address,
  output logic                     o_inst_response_valid,
  input  logic                     i_inst_response_ready,
  output logic [DATA_WIDTH-1:0]    o_inst_read_data,
  input  logic                     i_data_request_valid,
  output logic                     o_data_request_ready,
  input  logic [ADDRESS_WIDTH-1:0] i_data_address,
  input  logic                     i_data_write,
  input  logic [DATA_WIDTH-1:0]    i_data_write_data,
  input  logic [STROBE_WIDTH-1:0]  i_data_strobe,
  output logic                     o_data_response_valid,
  input  logic                     i_data_response_ready,
  output logic [DATA_WIDTH-1:0]    o_data_read_data,
  output logic                     o_mem_request_valid,
  input  logic                     i_mem_request_ready,
  output logic [ADDRESS_WIDTH-1:0] o_mem_address,
  output logic                     o_mem_write,
  output logic [DATA_WIDTH-1:0]    o_mem_write_data,
  output logic [STROBE_WIDTH-1:0]  o_mem_strobe,
  input  logic                     i_mem_response_valid,
  output logic                     o_mem_response_ready,
  input  logic [DATA_WIDTH-1:0]    i_mem_read_data,
  output logic                     o_protocol_error
);
  localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  logic [MAX_OUTSTANDING-1:0] ids;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic locked, lock_data, grant_data, full, empty, head, push, pop, protocol_error;
  assign full = count == CW'(MAX_OUTSTANDING);
  assign empty = count == '0;
  assign head = ids[rd_ptr];
`ifdef RICE_BUS_ARBITER_ROUND_ROBIN_EN
  logic last_data;
  assign grant_data = locked ? lock_data :
                      (i_data_request_valid && i_inst_request_valid) ? !last_data : i_data_request_valid;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) last_data <= 1'b1;
    else if (push) last_data <= grant_data;
`else
  assign grant_data = locked ? lock_data : i_data_request_valid;
`endif
  assign o_mem_request_valid = (grant_data ? i_data_request_valid : i_inst_request_valid) && !full;
  assign o_data_request_ready = grant_data && i_mem_request_ready && !full;
  assign o_inst_request_ready = !grant_data && i_mem_request_ready && !full;
  assign o_mem_address = grant_data ? i_data_address : i_inst_address;
  assign o_mem_write = grant_data && i_data_write;
  assign o_mem_write_data = grant_data ? i_data_write_data : '0;
  assign o_mem_strobe = grant_data ? i_data_strobe : '0;
  assign push = o_mem_request_valid && i_mem_request_ready;
  // an orphan response is drained so the memory side never stalls on it
  assign o_inst_response_valid = i_mem_response_valid && !empty && !head;
  assign o_data_response_valid = i_mem_response_valid && !empty && head;
  assign o_mem_response_ready = empty ? i_mem_response_valid : (head ? i_data_response_ready : i_inst_response_ready);
  assign pop = i_mem_response_valid && o_mem_response_ready && !empty;
  assign o_inst_read_data = i_mem_read_data;
  assign o_data_read_data = i_mem_read_data;
  assign o_protocol_error = protocol_error;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      ids <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      locked <= 1'b0;
      lock_data <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      if (push) begin
        ids[wr_ptr] <= grant_data;
        wr_ptr <= wr_ptr == PW'(MAX_OUTSTANDING - 1) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr == PW'(MAX_OUTSTANDING - 1) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      locked <= o_mem_request_valid && !i_mem_request_ready;
      lock_data <= grant_data;
      if (i_mem_response_valid && empty) protocol_error <= 1'b1;
    end
endmodule

// File: tb/tb_rice_core_bus_arbiter.sv
// tb_rice_core_bus_arbiter: directed and randomized scoreboard bench for rice_core_bus_arbiter.
`timescale 1ns/1ps
module tb_rice_core_bus_arbiter;
  localparam int MAXO = 2;
  logic clk = 0, rst_n = 0;
  logic inst_valid = 0, inst_rsp_ready = 0, data_valid = 0, data_write = 0, data_rsp_ready = 0;
  logic mem_req_ready = 0, mem_rsp_valid = 0;
  logic [31:0] inst_addr = 0, data_addr = 0, data_wdata = 0, mem_rdata = 0;
  logic [3:0] data_strobe = 0;
  logic inst_req_ready, inst_rsp_valid, data_req_ready, data_rsp_valid;
  logic mem_req_valid, mem_write, mem_rsp_ready, perr;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
  logic [3:0] mem_strobe;
  typedef struct packed {logic d; logic [31:0] v;} exp_t;
  exp_t exp_q[$];
  logic [31:0] mem_q[$];
  bit acc_log[$];
  bit locked_m = 0, lock_d_m = 0, last_d_m = 1, perr_m = 0;
  bit inst_fire, data_fire, mem_acc, rsp_fire, rnd = 0;
  logic [31:0] acc_data;
  int checks = 0, passed = 0, rsp_pct = 100;

  rice_core_bus_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_inst_request_valid(inst_valid), .o_inst_request_ready(inst_req_ready), .i_inst_address(inst_addr),
    .o_inst_response_valid(inst_rsp_valid), .i_inst_response_ready(inst_rsp_ready), .o_inst_read_data(inst_rdata),
    .i_data_request_valid(data_valid), .o_data_request_ready(data_req_ready), .i_data_address(data_addr),
    .i_data_write(data_write), .i_data_write_data(data_wdata), .i_data_strobe(data_strobe),
    .o_data_response_valid(data_rsp_valid), .i_data_response_ready(data_rsp_ready), .o_data_read_data(data_rdata),
    .o_mem_request_valid(mem_req_valid), .i_mem_request_ready(mem_req_ready), .o_mem_address(mem_addr),
    .o_mem_write(mem_write), .o_mem_write_data(mem_wdata), .o_mem_strobe(mem_strobe),
    .i_mem_response_valid(mem_rsp_valid), .o_mem_response_ready(mem_rsp_ready), .i_mem_read_data(mem_rdata),
    .o_protocol_error(perr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rdata(input logic [31:0] a);
    return a == 32'h100 ? 32'h13 : {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h, want %h", n, a, e);
  endtask

  task automatic chk1(input string n, input logic a, input logic e);
    checks++;
    if (a === e) passed++;
    else $display("FAIL %s: got %b, want %b", n, a, e);
  endtask

  // scoreboard monitor: outstanding responses are a queue of {destination, expected data}
  always @(negedge clk) begin
    int n;
    bit wd, wv, ev, d;
    n = exp_q.size();
    inst_fire = 0; data_fire = 0; mem_acc = 0; rsp_fire = 0;
    if (!rst_n) begin
      chk("reset_outputs", {25'd0, mem_req_valid, inst_req_ready, data_req_ready, inst_rsp_valid,
          data_rsp_valid, mem_rsp_ready, perr}, 32'd0);
      exp_q.delete();
      locked_m = 0; last_d_m = 1; perr_m = 0;
    end else begin
      wd = locked_m ? lock_d_m :
`ifdef RICE_BUS_ARBITER_ROUND_ROBIN_EN
           (inst_valid && data_valid) ? !last_d_m :
`endif
           data_valid;
      wv = wd ? data_valid : inst_valid;
      ev = wv && n < MAXO;
      chk1("mem_req_valid", mem_req_valid, ev);
      if (wv) begin
        chk1("inst_req_ready", inst_req_ready, !wd && mem_req_ready && n < MAXO);
        chk1("data_req_ready", data_req_ready, wd && mem_req_ready && n < MAXO);
      end
      if (ev) begin
        chk("mem_addr", mem_addr, wd ? data_addr : inst_addr);
        chk1("mem_write", mem_write, wd && data_write);
        chk("mem_wdata", mem_wdata, wd ? data_wdata : 32'd0);
        chk("mem_strobe", {28'd0, mem_strobe}, wd ? {28'd0, data_strobe} : 32'd0);
      end
      if (mem_rsp_valid && n == 0) begin
        chk1("orphan_ready", mem_rsp_ready, 1'b1);
        chk1("orphan_no_valid", inst_rsp_valid | data_rsp_valid, 1'b0);
      end else if (mem_rsp_valid) begin
        d = exp_q[0].d;
        chk1("inst_rsp_valid", inst_rsp_valid, !d);
        chk1("data_rsp_valid", data_rsp_valid, d);
        chk1("mem_rsp_ready", mem_rsp_ready, d ? data_rsp_ready : inst_rsp_ready);
        chk("inst_rdata", inst_rdata, exp_q[0].v);
        chk("data_rdata", data_rdata, exp_q[0].v);
      end else chk1("rsp_valid_idle", inst_rsp_valid | data_rsp_valid, 1'b0);
      chk1("protocol_error", perr, perr_m);
      if (mem_rsp_valid && n == 0) perr_m = 1;
      rsp_fire = mem_rsp_valid && mem_rsp_ready;
      if (rsp_fire && n > 0) void'(exp_q.pop_front());
      inst_fire = inst_valid && inst_req_ready;
      data_fire = data_valid && data_req_ready;
      mem_acc = mem_req_valid && mem_req_ready;
      acc_data = rdata(mem_addr);
      if (mem_acc) acc_log.push_back(data_req_ready);
      if (ev && mem_req_ready) begin
        exp_q.push_back('{wd, rdata(wd ? data_addr : inst_addr)});
        last_d_m = wd;
      end
      locked_m = ev && !mem_req_ready;
      lock_d_m = wd;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (mem_acc) mem_q.push_back(acc_data);
    if (rsp_fire) begin
      mem_rsp_valid = 0;
      if (mem_q.size() > 0) void'(mem_q.pop_front());
    end
    if (inst_fire) inst_valid = 0;
    if (data_fire) data_valid = 0;
    if (rnd) begin
      if (!inst_valid && $urandom_range(2) == 0) begin
        inst_valid = 1; inst_addr = $urandom & ~32'h3;
      end
      if (!data_valid && $urandom_range(2) == 0) begin
        data_valid = 1; data_addr = $urandom; data_write = 1'($urandom);
        data_wdata = $urandom; data_strobe = 4'($urandom);
      end
      mem_req_ready = $urandom_range(9) < 7;
      inst_rsp_ready = $urandom_range(9) < 7;
      data_rsp_ready = $urandom_range(9) < 7;
    end
    if (!mem_rsp_valid && mem_q.size() > 0 && $urandom_range(99) < rsp_pct) begin
      mem_rsp_valid = 1; mem_rdata = mem_q[0];
    end
  endtask

  task automatic idle(input int k);
    repeat (k) step();
  endtask

  task automatic do_reset();
    rst_n = 0; inst_valid = 0; data_valid = 0; mem_req_ready = 0; mem_rsp_valid = 0;
    step();
    rst_n = 1; mem_req_ready = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    inst_rsp_ready = 1; data_rsp_ready = 1; mem_req_ready = 1;
    inst_valid = 1; inst_addr = 32'h100;
    @(negedge clk);
    chk("t1_addr", mem_addr, 32'h100);
    chk1("t1_write", mem_write, 1'b0);
    step();
    @(negedge clk);
    chk1("t1_inst_rsp", inst_rsp_valid, 1'b1);
    chk("t1_rdata", inst_rdata, 32'h13);
    chk1("t1_data_rsp", data_rsp_valid, 1'b0);
    idle(4);

    do_reset();
    acc_log.delete();
    inst_valid = 1; inst_addr = 32'h200;
    data_valid = 1; data_addr = 32'h1000; data_write = 1; data_wdata = 32'hdead_beef; data_strobe = 4'hf;
    idle(6);
    chk("t2_grants", acc_log.size(), 32'd2);
    if (acc_log.size() == 2) begin
`ifdef RICE_BUS_ARBITER_ROUND_ROBIN_EN
      chk1("t2_first_inst", acc_log[0], 1'b0);
      chk1("t2_second_data", acc_log[1], 1'b1);
`else
      chk1("t2_first_data", acc_log[0], 1'b1);
      chk1("t2_second_inst", acc_log[1], 1'b0);
`endif
    end
    data_write = 0;

    mem_req_ready = 0; data_valid = 1; data_addr = 32'h2000;
    @(negedge clk) chk("t3_c0", mem_addr, 32'h2000);
    step();
    inst_valid = 1; inst_addr = 32'h300;
    @(negedge clk) chk("t3_c1", mem_addr, 32'h2000);
    step();
    @(negedge clk) chk("t3_c2", mem_addr, 32'h2000);
    step();
    mem_req_ready = 1;
    @(negedge clk) chk1("t3_data_accept", data_req_ready, 1'b1);
    step();
    @(negedge clk);
    chk("t3_inst_fwd", mem_addr, 32'h300);
    chk1("t3_inst_ready", inst_req_ready, 1'b1);
    idle(6);

    rsp_pct = 0;
    inst_valid = 1; inst_addr = 32'h400;
    step();
    data_valid = 1; data_addr = 32'h4000;
    step();
    inst_valid = 1; inst_addr = 32'h500;
    @(negedge clk) chk1("t4_full_block", mem_req_valid, 1'b0);
    step();
    @(negedge clk) chk1("t4_full_hold", mem_req_valid, 1'b0);
    rsp_pct = 100;
    step();
    rsp_pct = 0;
    @(negedge clk);
    chk1("t4_pop_cycle_block", mem_req_valid, 1'b0);
    chk1("t4_first_rsp_inst", inst_rsp_valid, 1'b1);
    step();
    @(negedge clk);
    chk1("t4_unblock", mem_req_valid, 1'b1);
    chk("t4_third_addr", mem_addr, 32'h500);
    rsp_pct = 100;
    step();
    @(negedge clk) chk1("t4_second_rsp_data", data_rsp_valid, 1'b1);
    idle(8);

    mem_rsp_valid = 1; mem_rdata = 32'hbad0_bad0;
    @(negedge clk);
    chk1("t5_drain_ready", mem_rsp_ready, 1'b1);
    chk1("t5_no_valid", inst_rsp_valid | data_rsp_valid, 1'b0);
    step();
    @(negedge clk) chk1("t5_perr", perr, 1'b1);
    idle(3);
    @(negedge clk) chk1("t5_sticky", perr, 1'b1);

    rsp_pct = 0;
    inst_valid = 1; inst_addr = 32'h600;
    step();
    data_valid = 1; data_addr = 32'h6000;
    step();
    rst_n = 0; inst_valid = 0; data_valid = 0; mem_req_ready = 0;
    @(negedge clk);
    chk1("t6_rst_valid", mem_req_valid | inst_rsp_valid | data_rsp_valid, 1'b0);
    chk1("t6_rst_perr", perr, 1'b0);
    step();
    rst_n = 1; mem_req_ready = 1;
    @(negedge clk) chk1("t6_perr_after_rst", perr, 1'b0);
    rsp_pct = 100;
    step();
    @(negedge clk) chk1("t6_stale_ready", mem_rsp_ready, 1'b1);
    step();
    @(negedge clk) chk1("t6_stale_perr", perr, 1'b1);
    idle(6);
    do_reset();

    rnd = 1; rsp_pct = 60;
    idle(3000);
    rnd = 0; rsp_pct = 100; inst_rsp_ready = 1; data_rsp_ready = 1; mem_req_ready = 1;
    for (int i = 0; i < 200 && (inst_valid || data_valid || mem_rsp_valid || mem_q.size() > 0); i++) step();
    idle(2);
    chk("drain_outstanding", exp_q.size(), 32'd0);
    chk("drain_memory", mem_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
